// File: rtl/prime_pkg.sv
// Shared types and constants for the prime sweep controller.
package prime_pkg;
    localparam int PRIME_WIDTH = 3;
    localparam int SETTLE_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    // Primes 2,3,5,7 over the full 3-bit range.
    localparam logic [7:0] PRIME_MAP_3B = 8'hAC;
endpackage

// File: rtl/prime_settle_timer.sv
// Loadable down-counter that holds each A value for the settle wait.
module prime_settle_timer
    import prime_pkg::*;
#(
    parameter int CW = SETTLE_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/prime_sweep_ctrl.sv
// Steps the prime checker's A through [lo, hi] and collects a prime bitmap and count.
//  state | meaning
//  IDLE  | waiting for start; bad range pulses err
//  SWEEP | driving A, waiting settle cycles, sampling prime_in
//  DONE  | one-cycle done pulse, results held
module prime_sweep_ctrl
    import prime_pkg::*;
#(
    parameter int WIDTH  = PRIME_WIDTH,
    parameter int SETTLE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      lo,
    input  logic [WIDTH-1:0]      hi,
    output logic [WIDTH-1:0]      A,
    input  logic                  prime_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2**WIDTH-1:0]   prime_map,
    output logic [WIDTH:0]        prime_cnt
);
    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

    sweep_state_t state, nstate;
    logic [WIDTH-1:0] hi_q;
    logic accept, bad_start, sample, last, tmr_load, tmr_dec, settle_zero;

    prime_settle_timer #(.CW(SETTLE_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_V),
        .dec      (tmr_dec),
        .zero     (settle_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate    = state;
        accept    = 1'b0;
        bad_start = 1'b0;
        sample    = 1'b0;
        last      = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (lo <= hi) begin
                        accept   = 1'b1;
                        tmr_load = 1'b1;
                        nstate   = SWEEP;
                    end else begin
                        bad_start = 1'b1;
                    end
                end
            end
            SWEEP: begin
                if (abort) begin
                    nstate = IDLE;
                end else if (!settle_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    sample = 1'b1;
                    // Compare before incrementing so hi = max never wraps A.
                    if (A == hi_q) begin
                        last   = 1'b1;
                        nstate = DONE;
                    end else begin
                        tmr_load = 1'b1;
                    end
                end
            end
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A         <= '0;
            hi_q      <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            prime_map <= '0;
            prime_cnt <= '0;
        end else begin
            err  <= bad_start;
            busy <= (nstate == SWEEP);
            if (accept) begin
                hi_q      <= hi;
                A         <= lo;
                prime_map <= '0;
                prime_cnt <= '0;
            end
            if (sample) begin
                prime_map[A] <= prime_in;
                prime_cnt    <= prime_cnt + {{WIDTH{1'b0}}, prime_in};
                if (!last) A <= A + WIDTH'(1);
            end
        end
    end

    assign done = (state == DONE);
endmodule
